// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall patterns and
// multi-cycle sequencer state encodings.
package pipe_stall_ctrl_pkg;

  localparam logic StallEnable  = 1'b1;
  localparam logic StallDisable = 1'b0;

  localparam int STALL_W = 6;

  // bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_stall_perf_cnt.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_stall_ctrl_stall_perf_cnt #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [PERF_W-1:0] cnt
);

  logic [PERF_W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment until all-ones, then hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                         cnt_d = '0;
    else if (inc && (cnt_q != '1))   cnt_d = cnt_q + PERF_W'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges ID/EX single-cycle stall requests with a
// multi-cycle EX hold sequencer and counts stalled cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                flush,
  input  logic                perf_clr,
  output logic [STALL_W-1:0]  stall,
  output logic                ex_mc_done,
  output logic                mc_busy,
  output logic [PERF_W-1:0]   stall_cycles
);

  mc_state_e             state_q, state_d;
  logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
  logic [MC_CNT_W-1:0]   mc_len;
  logic                  mc_accept;
  logic                  ex_side;

  // Op length with zero treated as a single cycle; start only honoured in IDLE
  always_comb begin
    mc_len    = (ex_mc_cycles == '0) ? MC_CNT_W'(1) : ex_mc_cycles;
    mc_accept = (state_q == ST_IDLE) && ex_mc_start;
  end

  // Sequencer state and down-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: flush cancels any hold; BUSY counts down to the DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mc_accept) begin
            if (mc_len == MC_CNT_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_BUSY;
              cnt_d   = mc_len - MC_CNT_W'(1);
            end
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q - MC_CNT_W'(1);
          if (cnt_q == MC_CNT_W'(1)) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: stall merge is combinational; done/busy decode registered state only.
  // Reset forces the stall vector low even though the request inputs may be high.
  always_comb begin
    ex_side    = stallreq_ex || mc_accept || (state_q == ST_BUSY);
    stall      = STALL_NONE;
    if (!rst || flush)    stall = STALL_NONE;
    else if (ex_side)     stall = STALL_EX;
    else if (stallreq_id) stall = STALL_ID;
    ex_mc_done = (state_q == ST_DONE);
    mc_busy    = (state_q == ST_BUSY);
  end

  pipe_stall_ctrl_stall_perf_cnt #(.PERF_W(PERF_W)) u_perf (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (stall[0] == StallEnable),
    .cnt (stall_cycles)
  );

endmodule
